// File: rtl/core_pkg.sv
// Shared types and constants for the fetch front-end: FSM states, default
// datapath width and redirect-source encoding.
package core_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_KILL = 2'd3
  } fetch_state_e;

  // Which redirect source won arbitration this cycle
  localparam logic [1:0] REDIR_NONE = 2'd0;
  localparam logic [1:0] REDIR_BR   = 2'd1;
  localparam logic [1:0] REDIR_RET  = 2'd2;
  localparam logic [1:0] REDIR_TRAP = 2'd3;

endpackage

// File: rtl/pc_next_sel.sv
// Redirect arbitration (trap > ret > branch) with alignment masking of the
// winning target and a flag when masking discarded set bits.
module pc_next_sel
  import core_pkg::*;
#(
  parameter int XLEN   = XLEN_DEFAULT,
  parameter int IALIGN = 4
) (
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_pc_i,
  input  logic            ret_valid_i,
  input  logic [XLEN-1:0] ret_pc_i,
  input  logic            br_valid_i,
  input  logic [XLEN-1:0] br_pc_i,
  output logic [1:0]      src_o,
  output logic [XLEN-1:0] target_o,
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

  logic [XLEN-1:0] raw_target;

  always_comb begin
    src_o      = REDIR_NONE;
    raw_target = br_pc_i;
    if (trap_valid_i) begin
      src_o      = REDIR_TRAP;
      raw_target = trap_pc_i;
    end else if (ret_valid_i) begin
      src_o      = REDIR_RET;
      raw_target = ret_pc_i;
    end else if (br_valid_i) begin
      src_o      = REDIR_BR;
      raw_target = br_pc_i;
    end
  end

  assign target_o   = raw_target & ~ALIGN_MASK;
  assign misalign_o = (src_o != REDIR_NONE) && (|(raw_target & ALIGN_MASK));

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch PC register, single-outstanding instruction-memory sequencer and
// one-entry output slot; redirects flush the slot and kill in-flight data.
module pc_fetch_unit
  import core_pkg::*;
#(
  parameter int              XLEN          = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_ADDRESS = '0,
  parameter int              IALIGN        = 4,
  parameter int              PC_STEP       = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            ret_valid,
  input  logic [XLEN-1:0] ret_pc,
  input  logic            br_valid,
  input  logic [XLEN-1:0] br_pc,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            fetch_valid,
  input  logic            fetch_ready,
  output logic [XLEN-1:0] fetch_pc,
  output logic [XLEN-1:0] fetch_inst,
  output logic            misalign_err,
  output logic [XLEN-1:0] pc_value
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            slot_valid_q, slot_valid_d;
  logic [XLEN-1:0] slot_pc_q, slot_pc_d;
  logic [XLEN-1:0] slot_inst_q, slot_inst_d;
  logic            misalign_q;

  logic [1:0]      redir_src;
  logic [XLEN-1:0] redir_target;
  logic            redir_misalign;
  logic            redir;
  logic            req_valid;
  logic            slot_fill;

  pc_next_sel #(
    .XLEN  (XLEN),
    .IALIGN(IALIGN)
  ) u_next_sel (
    .trap_valid_i(trap_valid),
    .trap_pc_i   (trap_pc),
    .ret_valid_i (ret_valid),
    .ret_pc_i    (ret_pc),
    .br_valid_i  (br_valid),
    .br_pc_i     (br_pc),
    .src_o       (redir_src),
    .target_o    (redir_target),
    .misalign_o  (redir_misalign)
  );

  assign redir = (redir_src != REDIR_NONE);

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    req_pc_d     = req_pc_q;
    slot_valid_d = slot_valid_q;
    slot_pc_d    = slot_pc_q;
    slot_inst_d  = slot_inst_q;
    req_valid    = 1'b0;
    slot_fill    = 1'b0;

    case (state_q)
      ST_BOOT: state_d = ST_REQ;
      ST_REQ: begin
        // Only issue when the slot will be free by the time data returns
        req_valid = !redir && (!slot_valid_q || fetch_ready);
        if (req_valid && imem_req_ready) begin
          req_pc_d = pc_q;
          pc_d     = pc_q + XLEN'(PC_STEP);
          state_d  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          state_d   = ST_REQ;
          slot_fill = !redir;
        end else if (redir) begin
          state_d = ST_KILL;
        end
      end
      ST_KILL: begin
        if (imem_rsp_valid) state_d = ST_REQ;
      end
      default: state_d = ST_BOOT;
    endcase

    if (redir) begin
      pc_d         = redir_target;
      slot_valid_d = 1'b0;
    end else if (slot_fill) begin
      slot_valid_d = 1'b1;
      slot_pc_d    = req_pc_q;
      slot_inst_d  = imem_rsp_data;
    end else if (fetch_ready && slot_valid_q) begin
      slot_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_BOOT;
      pc_q         <= RESET_ADDRESS;
      req_pc_q     <= '0;
      slot_valid_q <= 1'b0;
      slot_pc_q    <= '0;
      slot_inst_q  <= '0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_pc_q     <= req_pc_d;
      slot_valid_q <= slot_valid_d;
      slot_pc_q    <= slot_pc_d;
      slot_inst_q  <= slot_inst_d;
      misalign_q   <= redir_misalign;
    end
  end

  assign imem_req_valid = req_valid;
  assign imem_req_addr  = pc_q;
  assign fetch_valid    = slot_valid_q;
  assign fetch_pc       = slot_pc_q;
  assign fetch_inst     = slot_inst_q;
  assign misalign_err   = misalign_q;
  assign pc_value       = pc_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: a transaction-level memory/PC/slot model
// predicts requests and delivered instructions; a monitor checks decode output.
module tb_pc_fetch_unit;

  localparam int          XLEN     = 32;
  localparam int          IALIGN   = 4;
  localparam logic [31:0] RST_ADDR = 32'h8000_0000;

  logic            clk = 1'b0;
  logic            rst;
  logic            trap_valid, ret_valid, br_valid;
  logic [XLEN-1:0] trap_pc, ret_pc, br_pc;
  logic            imem_req_valid, imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [XLEN-1:0] imem_rsp_data;
  logic            fetch_valid, fetch_ready;
  logic [XLEN-1:0] fetch_pc, fetch_inst;
  logic            misalign_err;
  logic [XLEN-1:0] pc_value;

  pc_fetch_unit #(
    .XLEN         (XLEN),
    .RESET_ADDRESS(RST_ADDR),
    .IALIGN       (IALIGN),
    .PC_STEP      (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .trap_valid    (trap_valid),
    .trap_pc       (trap_pc),
    .ret_valid     (ret_valid),
    .ret_pc        (ret_pc),
    .br_valid      (br_valid),
    .br_pc         (br_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .fetch_valid   (fetch_valid),
    .fetch_ready   (fetch_ready),
    .fetch_pc      (fetch_pc),
    .fetch_inst    (fetch_inst),
    .misalign_err  (misalign_err),
    .pc_value      (pc_value)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_t;
  fetch_t exp_q[$];

  // Transaction-level model state
  logic [31:0] exp_pc;
  bit          exp_slot;
  bit          exp_mis;
  bit          boot;
  bit          outstanding;
  bit          killed;
  int          rsp_wait;
  logic [31:0] out_pc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    {trap_valid, ret_valid, br_valid, imem_req_ready, imem_rsp_valid, fetch_ready} = '0;
    trap_pc = '0; ret_pc = '0; br_pc = '0; imem_rsp_data = '0;
    exp_q.delete();
    outstanding = 0; killed = 0; rsp_wait = 0;
    exp_slot = 0; exp_mis = 0; exp_pc = RST_ADDR;
    #1;
    check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    check("rst_fetch_pc", fetch_pc, 32'd0);
    check("rst_fetch_inst", fetch_inst, 32'd0);
    check("rst_misalign", {31'b0, misalign_err}, 32'd0);
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    check("rst_pc_value", pc_value, RST_ADDR);
    @(negedge clk);
    @(negedge clk);
    rst  = 1'b0;
    boot = 1;
    $display("reset released, pc=%h", RST_ADDR);
  endtask

  // One clock cycle of stimulus, starting at a falling edge
  task automatic cycle(input bit tv, input logic [31:0] tp, input bit rv, input logic [31:0] rp,
                       input bit bv, input logic [31:0] bp, input bit fr, input bit rr,
                       input int lat);
    bit          redir, rsp_now, fill, exp_req;
    logic [31:0] sel, data;
    if (boot) begin
      tv = 0; rv = 0; bv = 0;
    end
    redir   = tv | rv | bv;
    sel     = tv ? tp : (rv ? rp : bp);
    rsp_now = outstanding && (rsp_wait == 0);
    data    = $urandom;
    trap_valid = tv; trap_pc = tp;
    ret_valid  = rv; ret_pc  = rp;
    br_valid   = bv; br_pc   = bp;
    fetch_ready    = fr;
    imem_req_ready = rr;
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = data;
    #1;
    exp_req = !boot && !outstanding && !redir && (!exp_slot || fr);
    check("pc_value", pc_value, exp_pc);
    check("fetch_valid", {31'b0, fetch_valid}, {31'b0, exp_slot});
    check("misalign_err", {31'b0, misalign_err}, {31'b0, exp_mis});
    check("req_valid", {31'b0, imem_req_valid}, {31'b0, exp_req});
    if (exp_req) check("req_addr", imem_req_addr, exp_pc);

    exp_mis = redir && ((sel % IALIGN) != 0);
    if (outstanding && redir) killed = 1;
    fill = rsp_now && !killed;
    if (redir) begin
      if (exp_slot && !fr) void'(exp_q.pop_front());
      exp_slot = 0;
    end else if (fill) begin
      exp_q.push_back('{pc: out_pc, inst: data});
      exp_slot = 1;
    end else if (exp_slot && fr) begin
      exp_slot = 0;
    end
    if (rsp_now) outstanding = 0;
    else if (outstanding) rsp_wait--;
    if (exp_req && rr) begin
      outstanding = 1; killed = 0; out_pc = exp_pc; rsp_wait = lat - 1;
      $display("request addr=%h lat=%0d", exp_pc, lat);
      exp_pc = exp_pc + 32'd4;
    end
    if (redir) begin
      exp_pc = sel - (sel % IALIGN);
      $display("redirect target=%h aligned=%h", sel, exp_pc);
    end
    boot = 0;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit fr, input bit rr, input int lat);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 0, 0, fr, rr, lat);
  endtask

  // Monitor: checks every instruction decode actually consumes
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (!rst && fetch_valid && fetch_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL fetch_unexpected actual_pc=%h required=none", fetch_pc);
        end else begin
          fetch_t e;
          e = exp_q.pop_front();
          check("fetch_pc", fetch_pc, e.pc);
          check("fetch_inst", fetch_inst, e.inst);
          $display("consume pc=%h inst=%h", fetch_pc, fetch_inst);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // Sequential fetch from the reset vector with a 1-cycle memory
    idle(8, 1, 1, 1);
    // Branch while waiting on a slow response: response must be killed
    for (int i = 0; i < 10 && !outstanding; i++) idle(1, 1, 1, 3);
    cycle(0, 0, 0, 0, 1, 32'h100, 1, 1, 1);
    idle(6, 1, 1, 1);
    // All three redirect sources at once: trap wins
    cycle(1, 32'h200, 1, 32'h300, 1, 32'h400, 1, 1, 1);
    idle(4, 1, 1, 1);
    // Misaligned branch target
    cycle(0, 0, 0, 0, 1, 32'h106, 1, 1, 1);
    idle(4, 1, 1, 1);
    // Decode stalls with a full slot, then releases
    idle(8, 0, 1, 1);
    idle(4, 1, 1, 1);
    // Memory back-pressure
    idle(3, 1, 0, 1);
    idle(4, 1, 1, 1);
    // PC wrap at the top of the address space
    for (int i = 0; i < 10 && outstanding; i++) idle(1, 1, 1, 1);
    cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, 1);
    idle(6, 1, 1, 1);

    // Randomized traffic with one mid-run reset
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      cycle($urandom_range(0, 99) < 3, $urandom,
            $urandom_range(0, 99) < 3, $urandom,
            $urandom_range(0, 99) < 8, $urandom,
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 70,
            int'($urandom_range(1, 3)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
